matrix_op_mul: RTL and testbench
================================

# matrix_op_mul

Matrix-multiply operator: reads operand matrices A and B from the shared matrix BRAM, computes C = A × B in signed 32-bit arithmetic, and streams C into result slot 0 through the matrix writer. It sits beside the other `matrix_op_*` engines under the operation dispatcher, sharing one BRAM read port and the writer handshake.

## Interface
Parameters come from `matrix_op_defs_pkg` and are not overridden per instance:
- `DATA_WIDTH`, default `MATRIX_DATA_WIDTH` (32): BRAM word width.
- `ADDR_WIDTH`, default `MATRIX_ADDR_WIDTH`: BRAM address width.
- `BLOCK_SIZE`, default `MATRIX_BLOCK_SIZE`: words per matrix slot; the slot base address is `id*BLOCK_SIZE`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse; accepted only while idle.
- `matrix_a_id`, `matrix_b_id`  in  3 each: operand slot IDs.
- `busy`  out  1: high while an operation is in progress.
- `status`  out  `matrix_op_status_e`: result of the last operation.
- `read_addr`  out  ADDR_WIDTH: BRAM read address.
- `data_out`  in  32: BRAM read data, combinational (same cycle as `read_addr`).
- `write_request`  out  1: asks the writer to start a result write.
- `write_ready`  in  1: writer is idle.
- `matrix_id`  out  3: result slot; always 0.
- `actual_rows`, `actual_cols`  out  8 each: result dimensions.
- `matrix_name`  out  8×8 bytes: result name.
- `data_in`  out  32: result element.
- `data_valid`  out  1: `data_in` is valid.
- `writer_ready`  in  1: writer accepts data this cycle.
- `write_done`  in  1: writer finished (one-cycle pulse).

## Operation
Slot layout:
- Word 0: `{rows[31:24], cols[23:16], 16'h0}`.
- Words 1–2: name bytes 0–3 and 4–7, MSB-first.
- From word `MATRIX_METADATA_WORDS` (3): data, row-major.

States are IDLE, RD_META_A, RD_META_B, CHECK, REQ, RD_A, RD_B, EMIT, WAIT_DONE, FINISH.
- **IDLE:** on `start`, latch both IDs and go to RD_META_A.
- **RD_META_A / RD_META_B:** drive the slot base address; latch rows/cols from `data_out`.
- **CHECK**, first match wins:
  - Either ID == 0 → `ERR_ID`.
  - colsA ≠ rowsB, or any dimension == 0 → `ERR_DIM`.
  - rowsA·colsB + 3 > BLOCK_SIZE → `ERR_DIM`.
  - Errors go to FINISH without touching the writer.
- **REQ:** hold `write_request` with `matrix_id`=0, `actual_rows`=rowsA, `actual_cols`=colsB, `matrix_name`="MUL_RES"+0x00. Leave when `write_request && write_ready` are both high on a clock edge.
- For each (i, j) in row-major order, for k = 0..colsA-1:
  - RD_A: address A[i][k]; latch `data_out`.
  - RD_B: address B[k][j]; acc += a·b as signed.
- **EMIT:** drive `data_in` = acc with `data_valid` = 1. Hold until a cycle where `writer_ready` = 1, which consumes the element. Clear acc, then advance j, then i.
- **WAIT_DONE:** after the last element, wait for `write_done`; status becomes `SUCCESS`.
- **FINISH:** update `status`, drop `busy`, return to IDLE.

Arithmetic: 32×32 signed products, accumulated modulo 2^32 (wrap) unless the saturation macro is defined (see Configuration).

## Timing
- Reset values: `busy`=0, `status`=IDLE, `write_request`=0, `data_valid`=0, `read_addr`=0, `data_in`=0, `matrix_id`=0, dims=0, name=0.
- `busy` rises the cycle after `start` is sampled and stays high through FINISH.
- `status` updates in the same cycle `busy` falls and holds until the next operation completes.
- `start` while busy is ignored.
- Each dot-product term costs 2 cycles. With zero writer stall, each element costs 2·colsA + 1 cycles.
- `data_valid` is never high outside EMIT. Exactly rowsA·colsB beats are accepted.
- `rst` mid-operation returns the block to IDLE and clears all outputs next edge. The partial write is abandoned.

## Configuration
- `MATRIX_OP_MUL_SATURATE_EN` defined: accumulate in 64 bits; on emit, clamp to [−2^31, 2^31−1].
- Undefined: 32-bit wrap-around accumulation.

## Structure
- `matrix_op_defs_pkg` holds:
  - `MATRIX_DATA_WIDTH`, `MATRIX_ADDR_WIDTH`, `MATRIX_BLOCK_SIZE`, `MATRIX_METADATA_WORDS`.
  - `matrix_op_status_e`: IDLE=0, SUCCESS=1, ERR_DIM=2, ERR_ID=3.
- One natural sub-module: `matrix_op_mac` (signed multiply-accumulate with clear, honouring the macro).

## Test plan
- A(id1, 2×3: 1..6) × B(id2, 3×2: 7..12) → SUCCESS; slot 0 = 58, 64, 139, 154; header rows=2, cols=2.
- C(id3, [2, 0; −1, 3]) × D(id4, [4, 1; 5, 2]) → SUCCESS; slot 0 = 8, 2, 11, 5 (signed).
- E(id5, 3×4: 1..12) × F(id6, 4×2: [1, 2; 0, 1; 2, 0; 1, 1]) → 11, 8, 27, 24, 43, 40.
- A(2×3) × C(2×2) → `ERR_DIM`; no `write_request` asserted.
- `matrix_a_id`=0, `matrix_b_id`=2 → `ERR_ID`; `busy` pulses.
- Writer holds `writer_ready` low for random cycles mid-stream → identical results, no duplicated or lost elements.

Source files
------------

// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix_op_* engines: BRAM geometry, slot layout, status codes
// and the matrix-multiply engine's FSM states.
package matrix_op_defs_pkg;

   localparam int MATRIX_DATA_WIDTH     = 32;
   localparam int MATRIX_ADDR_WIDTH     = 10;
   localparam int MATRIX_BLOCK_SIZE     = 64;
   localparam int MATRIX_METADATA_WORDS = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SUCCESS = 2'd1,
      ERR_DIM = 2'd2,
      ERR_ID  = 2'd3
   } matrix_op_status_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_META_A,
      ST_RD_META_B,
      ST_CHECK,
      ST_REQ,
      ST_RD_A,
      ST_RD_B,
      ST_EMIT,
      ST_WAIT_DONE,
      ST_FINISH
   } matrix_op_mul_state_e;

   // "MUL_RES" followed by a NUL; byte 0 is the first character
   localparam logic [7:0][7:0] MUL_RES_NAME = 64'h0053_4552_5F4C_554D;

   function automatic logic [31:0] slot_addr(input logic [2:0] id, input logic [31:0] word,
                                             input int unsigned block);
      return 32'(id) * block + word;
   endfunction

endpackage

// File: rtl/matrix_op_mul_mac.sv
// Signed 32x32 multiply-accumulate with synchronous clear.
// MATRIX_OP_MUL_SATURATE_EN: 64-bit accumulator clamped to int32 on output; otherwise 32-bit wrap.
module matrix_op_mac (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [31:0] result
);

`ifdef MATRIX_OP_MUL_SATURATE_EN
   localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
   localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

   logic signed [63:0] acc;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + 64'(a) * 64'(b);
      end
   end

   always_comb begin
      result = acc[31:0];
      if (acc > SAT_MAX) begin
         result = SAT_MAX[31:0];
      end else if (acc < SAT_MIN) begin
         result = SAT_MIN[31:0];
      end
   end
`else
   logic signed [31:0] acc;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + a * b;
      end
   end

   assign result = acc;
`endif

endmodule

// File: rtl/matrix_op_mul.sv
// Matrix-multiply engine: reads A and B slots from the shared BRAM and streams C = A x B to slot 0.
// Optional saturating accumulation via MATRIX_OP_MUL_SATURATE_EN (see matrix_op_mac).
module matrix_op_mul
   import matrix_op_defs_pkg::*;
#(
   parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
   parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
   parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            matrix_a_id,
   input  logic [2:0]            matrix_b_id,
   output logic                  busy,
   output matrix_op_status_e     status,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  write_request,
   input  logic                  write_ready,
   output logic [2:0]            matrix_id,
   output logic [7:0]            actual_rows,
   output logic [7:0]            actual_cols,
   output logic [7:0][7:0]       matrix_name,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  data_valid,
   input  logic                  writer_ready,
   input  logic                  write_done
);

   localparam logic [31:0] META = 32'(MATRIX_METADATA_WORDS);

   matrix_op_mul_state_e state, next;
   matrix_op_status_e    err, check_res;
   logic [2:0]           a_id, b_id;
   logic [7:0]           rows_a, cols_a, rows_b, cols_b;
   logic [7:0]           i, j, k;
   logic [31:0]          a_val;
   logic                 mac_en, mac_clr;
   logic signed [31:0]   mac_result;

   matrix_op_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (mac_clr),
      .en     (mac_en),
      .a      (a_val),
      .b      (data_out),
      .result (mac_result)
   );

   always_comb begin
      check_res = SUCCESS;
      if (a_id == '0 || b_id == '0) begin
         check_res = ERR_ID;
      end else if (cols_a != rows_b || rows_a == '0 || cols_a == '0 ||
                   rows_b == '0 || cols_b == '0) begin
         check_res = ERR_DIM;
      end else if (32'(rows_a) * 32'(cols_b) + META > 32'(BLOCK_SIZE)) begin
         check_res = ERR_DIM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next          = state;
      busy          = (state != ST_IDLE);
      read_addr     = '0;
      write_request = 1'b0;
      data_valid    = 1'b0;
      data_in       = '0;
      matrix_id     = '0;
      actual_rows   = '0;
      actual_cols   = '0;
      matrix_name   = '0;
      mac_en        = 1'b0;
      mac_clr       = 1'b0;
      if (state inside {ST_REQ, ST_RD_A, ST_RD_B, ST_EMIT, ST_WAIT_DONE}) begin
         actual_rows = rows_a;
         actual_cols = cols_b;
         matrix_name = MUL_RES_NAME;
      end
      case (state)
         ST_IDLE:      if (start) next = ST_RD_META_A;
         ST_RD_META_A: begin
            read_addr = ADDR_WIDTH'(slot_addr(a_id, 32'd0, BLOCK_SIZE));
            next      = ST_RD_META_B;
         end
         ST_RD_META_B: begin
            read_addr = ADDR_WIDTH'(slot_addr(b_id, 32'd0, BLOCK_SIZE));
            next      = ST_CHECK;
         end
         ST_CHECK: begin
            mac_clr = 1'b1;
            next    = (check_res == SUCCESS) ? ST_REQ : ST_FINISH;
         end
         ST_REQ: begin
            write_request = 1'b1;
            if (write_ready) next = ST_RD_A;
         end
         ST_RD_A: begin
            read_addr = ADDR_WIDTH'(slot_addr(a_id, META + 32'(i) * 32'(cols_a) + 32'(k),
                                              BLOCK_SIZE));
            next      = ST_RD_B;
         end
         ST_RD_B: begin
            read_addr = ADDR_WIDTH'(slot_addr(b_id, META + 32'(k) * 32'(cols_b) + 32'(j),
                                              BLOCK_SIZE));
            mac_en    = 1'b1;
            next      = (k == cols_a - 8'd1) ? ST_EMIT : ST_RD_A;
         end
         ST_EMIT: begin
            data_valid = 1'b1;
            data_in    = mac_result;
            if (writer_ready) begin
               mac_clr = 1'b1;
               next    = (j == cols_b - 8'd1 && i == rows_a - 8'd1) ? ST_WAIT_DONE : ST_RD_A;
            end
         end
         ST_WAIT_DONE: if (write_done) next = ST_FINISH;
         ST_FINISH:    next = ST_IDLE;
         default:      next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status <= IDLE;
         err    <= IDLE;
         a_id   <= '0;
         b_id   <= '0;
         rows_a <= '0;
         cols_a <= '0;
         rows_b <= '0;
         cols_b <= '0;
         i      <= '0;
         j      <= '0;
         k      <= '0;
         a_val  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               a_id <= matrix_a_id;
               b_id <= matrix_b_id;
            end
            ST_RD_META_A: begin
               rows_a <= data_out[31:24];
               cols_a <= data_out[23:16];
            end
            ST_RD_META_B: begin
               rows_b <= data_out[31:24];
               cols_b <= data_out[23:16];
            end
            ST_CHECK: begin
               err <= check_res;
               i   <= '0;
               j   <= '0;
               k   <= '0;
            end
            ST_RD_A: a_val <= data_out;
            ST_RD_B: k <= (k == cols_a - 8'd1) ? '0 : k + 8'd1;
            ST_EMIT: if (writer_ready) begin
               if (j == cols_b - 8'd1) begin
                  j <= '0;
                  i <= i + 8'd1;
               end else begin
                  j <= j + 8'd1;
               end
            end
            ST_WAIT_DONE: if (write_done) err <= SUCCESS;
            ST_FINISH:    status <= err;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_op_mul.sv
// Bench for matrix_op_mul: BRAM array, writer responder, and a plain-arithmetic matrix model.
module tb_matrix_op_mul;
   import matrix_op_defs_pkg::*;

   localparam int BS = MATRIX_BLOCK_SIZE;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         start = 1'b0;
   logic [2:0]                   matrix_a_id = '0, matrix_b_id = '0;
   logic                         busy;
   matrix_op_status_e            status;
   logic [MATRIX_ADDR_WIDTH-1:0] read_addr;
   logic [31:0]                  data_out;
   logic                         write_request;
   logic                         write_ready = 1'b1;
   logic [2:0]                   matrix_id;
   logic [7:0]                   actual_rows, actual_cols;
   logic [7:0][7:0]              matrix_name;
   logic [31:0]                  data_in;
   logic                         data_valid;
   logic                         writer_ready = 1'b0;
   logic                         write_done = 1'b0;

   logic [31:0] mem [0:8*BS-1];
   assign data_out = mem[read_addr];

   always #5 clk = ~clk;

   matrix_op_mul dut (
      .clk(clk), .rst(rst), .start(start), .matrix_a_id(matrix_a_id), .matrix_b_id(matrix_b_id),
      .busy(busy), .status(status), .read_addr(read_addr), .data_out(data_out),
      .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
      .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(matrix_name),
      .data_in(data_in), .data_valid(data_valid), .writer_ready(writer_ready),
      .write_done(write_done)
   );

   int          checks = 0;
   int          errors = 0;
   bit          stall_en = 1'b0;

   // Writer responder: decides its inputs at negedge for the following posedge
   int          phase = 0;
   int unsigned total = 0, cnt = 0, req_cnt = 0, dv_bad = 0;
   logic [7:0]  hdr_rows = '0, hdr_cols = '0;
   logic [2:0]  hdr_id = '0;
   logic [7:0][7:0] hdr_name = '0;
   logic [31:0] got[$];

   always @(negedge clk) begin
      if (rst) begin
         phase = 0; write_ready = 1'b1; writer_ready = 1'b0; write_done = 1'b0;
      end else begin
         if (data_valid && phase != 1) dv_bad++;
         case (phase)
            0: begin
               write_ready = 1'b1; writer_ready = 1'b0; write_done = 1'b0;
               if (write_request) begin
                  req_cnt++;
                  hdr_rows = actual_rows; hdr_cols = actual_cols;
                  hdr_id = matrix_id; hdr_name = matrix_name;
                  total = 32'(actual_rows) * 32'(actual_cols); cnt = 0;
                  phase = 1;
               end
            end
            1: begin
               write_ready = 1'b0;
               writer_ready = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
               if (data_valid && writer_ready) begin
                  got.push_back(data_in);
                  cnt++;
                  if (cnt == total) phase = 2;
               end
            end
            default: begin
               writer_ready = 1'b0; write_done = 1'b1; phase = 0;
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_slot(input int id, input int rows, input int cols, input int vals[$]);
      mem[id*BS]     = {rows[7:0], cols[7:0], 16'h0};
      mem[id*BS + 1] = 32'h4D41_5452;
      mem[id*BS + 2] = 32'h0000_0000 + id;
      for (int n = 0; n < vals.size(); n++) mem[id*BS + 3 + n] = vals[n];
   endtask

   function automatic matrix_op_status_e ref_status(input int a, input int b);
      int ra, ca, rb, cb;
      if (a == 0 || b == 0) return ERR_ID;
      ra = int'(mem[a*BS][31:24]); ca = int'(mem[a*BS][23:16]);
      rb = int'(mem[b*BS][31:24]); cb = int'(mem[b*BS][23:16]);
      if (ca != rb || ra == 0 || ca == 0 || rb == 0 || cb == 0) return ERR_DIM;
      if (ra * cb + 3 > BS) return ERR_DIM;
      return SUCCESS;
   endfunction

   logic [31:0] expq[$];

   task automatic ref_product(input int a, input int b);
      int ra, ca, cb;
      longint s;
      expq.delete();
      ra = int'(mem[a*BS][31:24]); ca = int'(mem[a*BS][23:16]); cb = int'(mem[b*BS][23:16]);
      for (int r = 0; r < ra; r++)
         for (int c = 0; c < cb; c++) begin
            s = 0;
            for (int n = 0; n < ca; n++)
               s += longint'($signed(mem[a*BS + 3 + r*ca + n])) *
                    longint'($signed(mem[b*BS + 3 + n*cb + c]));
`ifdef MATRIX_OP_MUL_SATURATE_EN
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
            expq.push_back(s[31:0]);
         end
   endtask

   task automatic run_op(input int a, input int b, input bit stall, input bit poke);
      matrix_op_status_e es;
      int unsigned g0, r0;
      int cyc;
      logic [7:0][7:0] en;
      string nm = "MUL_RES";
      for (int n = 0; n < 7; n++) en[n] = nm[n];
      en[7] = 8'h00;
      es = ref_status(a, b);
      if (es == SUCCESS) ref_product(a, b);
      g0 = got.size(); r0 = req_cnt; stall_en = stall;
      @(negedge clk); start = 1'b1; matrix_a_id = a[2:0]; matrix_b_id = b[2:0];
      @(negedge clk); start = 1'b0;
      chk("busy_rise", busy, 1);
      if (poke) begin
         start = 1'b1; matrix_a_id = 3'd7; matrix_b_id = 3'd1;
         @(negedge clk); start = 1'b0;
      end
      cyc = 0;
      while (busy && cyc < 5000) begin @(negedge clk); cyc++; end
      chk("done_in_time", cyc < 5000, 1);
      chk("status", status, es);
      chk("req_count", req_cnt - r0, es == SUCCESS);
      if (es == SUCCESS) begin
         chk("hdr_rows", hdr_rows, mem[a*BS][31:24]);
         chk("hdr_cols", hdr_cols, mem[b*BS][23:16]);
         chk("hdr_id", hdr_id, 0);
         chk("hdr_name", hdr_name, en);
         chk("beats", got.size() - g0, expq.size());
         for (int n = 0; n < expq.size() && g0 + n < got.size(); n++)
            chk($sformatf("elem%0d", n), got[g0 + n], expq[n]);
      end
      chk("dv_outside_emit", dv_bad, 0);
      repeat (3) @(negedge clk);
      chk("status_hold", status, es);
   endtask

   initial begin
      int ra, ca, cb;
      int v[$];
      for (int n = 0; n < 8*BS; n++) mem[n] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_status", status, IDLE);
      chk("rst_wreq", write_request, 0);
      chk("rst_dvalid", data_valid, 0);
      chk("rst_raddr", read_addr, 0);
      chk("rst_din", data_in, 0);
      chk("rst_mid", matrix_id, 0);
      chk("rst_rows", actual_rows, 0);
      chk("rst_cols", actual_cols, 0);
      chk("rst_name", matrix_name, 0);
      rst = 1'b0;

      load_slot(1, 2, 3, '{1, 2, 3, 4, 5, 6});
      load_slot(2, 3, 2, '{7, 8, 9, 10, 11, 12});
      load_slot(3, 2, 2, '{2, 0, -1, 3});
      load_slot(4, 2, 2, '{4, 1, 5, 2});
      load_slot(5, 3, 4, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12});
      load_slot(6, 4, 2, '{1, 2, 0, 1, 2, 0, 1, 1});
      run_op(1, 2, 1'b0, 1'b0);
      chk("ab_c00", got[got.size()-4], 58);
      chk("ab_c11", got[got.size()-1], 154);
      run_op(3, 4, 1'b0, 1'b0);
      run_op(5, 6, 1'b1, 1'b1);
      run_op(1, 3, 1'b0, 1'b0);
      run_op(0, 2, 1'b0, 1'b0);
      run_op(1, 0, 1'b0, 1'b0);
      load_slot(7, 0, 3, '{});
      run_op(7, 2, 1'b0, 1'b0);
      run_op(1, 2, 1'b1, 1'b0);

      // result capacity boundary: 7x8 fits (59 words), 8x8 does not (67 words)
      load_slot(6, 1, 8, '{3, -1, 4, 1, -5, 9, 2, -6});
      load_slot(7, 7, 1, '{1, 2, 3, 4, 5, 6, 7});
      run_op(7, 6, 1'b0, 1'b0);
      load_slot(7, 8, 1, '{1, 2, 3, 4, 5, 6, 7, 8});
      run_op(7, 6, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         ra = $urandom_range(1, 4); ca = $urandom_range(1, 4); cb = $urandom_range(1, 4);
         v.delete();
         for (int n = 0; n < ra*ca; n++)
            v.push_back((t % 2) ? int'($urandom) : $urandom_range(0, 200) - 100);
         load_slot(1, ra, ca, v);
         v.delete();
         for (int n = 0; n < ca*cb; n++)
            v.push_back((t % 2) ? int'($urandom) : $urandom_range(0, 200) - 100);
         load_slot(2, ca, cb, v);
         run_op(1, 2, t % 3 != 0, t % 4 == 1);
      end

      // reset while streaming abandons the operation
      load_slot(1, 3, 3, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
      load_slot(2, 3, 3, '{9, 8, 7, 6, 5, 4, 3, 2, 1});
      stall_en = 1'b1;
      @(negedge clk); start = 1'b1; matrix_a_id = 3'd1; matrix_b_id = 3'd2;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_status", status, IDLE);
      chk("mid_rst_wreq", write_request, 0);
      chk("mid_rst_dvalid", data_valid, 0);
      chk("mid_rst_din", data_in, 0);
      chk("mid_rst_raddr", read_addr, 0);
      chk("mid_rst_rows", actual_rows, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      run_op(1, 2, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
